// File: rtl/pulse_sequencer.sv
// Periodic RF pulse / sync / attenuator gate generator with shadowed timing
// parameters that are captured at LOAD and at every period wrap.
module pulse_sequencer #(
    parameter logic [31:0] MIN_PER = 32'd16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] per,
    input  logic [CNT_W-1:0] p1wid,
    input  logic [CNT_W-1:0] p2st,
    input  logic [CNT_W-1:0] p2wid,
    input  logic [CNT_W-1:0] s_up,
    input  logic [CNT_W-1:0] att_d,
    input  logic [CNT_W-1:0] offr_d,
    input  logic             pu,
    input  logic             doub,
    output logic             pulse,
    output logic             sync,
    output logic             att,
    output logic             stb,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

    localparam logic [CNT_W-1:0] RST_PER    = CNT_W'(200000);
    localparam logic [CNT_W-1:0] RST_P1WID  = CNT_W'(30);
    localparam logic [CNT_W-1:0] RST_P2ST   = CNT_W'(230);
    localparam logic [CNT_W-1:0] RST_P2WID  = CNT_W'(30);
    localparam logic [CNT_W-1:0] RST_S_UP   = CNT_W'(260);
    localparam logic [CNT_W-1:0] RST_ATT_D  = CNT_W'(20260);
    localparam logic [CNT_W-1:0] RST_OFFR_D = CNT_W'(191970);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] sh_per_q, sh_per_d, sh_p1wid_q, sh_p1wid_d;
    logic [CNT_W-1:0] sh_p2st_q, sh_p2st_d, sh_p2wid_q, sh_p2wid_d;
    logic [CNT_W-1:0] sh_s_up_q, sh_s_up_d, sh_att_d_q, sh_att_d_d;
    logic [CNT_W-1:0] sh_offr_d_q, sh_offr_d_d;
    logic             sh_pu_q, sh_pu_d, sh_doub_q, sh_doub_d;
    logic             pulse_q, pulse_d, sync_q, sync_d;
    logic             att_gate_q, att_gate_d, stb_q, stb_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_ok, wrap, capture;
    logic             run_n, win_p1, win_p2, win_off;
    logic [CNT_W:0]   c_ext, p2_end, off_end;

    always_comb begin
        cfg_ok = (per >= CNT_W'(MIN_PER)) && (p1wid < per) && (s_up < per)
              && (att_d <= per) && (offr_d < per);
        wrap    = (state_q == RUN) && (phase_q == sh_per_q - CNT_W'(1));
        capture = (state_q == LOAD) || wrap;

        state_d     = state_q;
        phase_d     = phase_q;
        sh_per_d    = sh_per_q;
        sh_p1wid_d  = sh_p1wid_q;
        sh_p2st_d   = sh_p2st_q;
        sh_p2wid_d  = sh_p2wid_q;
        sh_s_up_d   = sh_s_up_q;
        sh_att_d_d  = sh_att_d_q;
        sh_offr_d_d = sh_offr_d_q;
        sh_pu_d     = sh_pu_q;
        sh_doub_d   = sh_doub_q;
        cfg_err_d   = cfg_err_q;

        if (capture) begin
            if (cfg_ok) begin
                sh_per_d    = per;
                sh_p1wid_d  = p1wid;
                sh_p2st_d   = p2st;
                sh_p2wid_d  = p2wid;
                sh_s_up_d   = s_up;
                sh_att_d_d  = att_d;
                sh_offr_d_d = offr_d;
                sh_pu_d     = pu;
                sh_doub_d   = doub;
                cfg_err_d   = 1'b0;
            end else begin
                cfg_err_d   = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (en) state_d = LOAD;
            end
            // An invalid first capture never starts the sequencer.
            LOAD: begin
                phase_d = '0;
                state_d = cfg_ok ? RUN : IDLE;
            end
            RUN: begin
                if (wrap) begin
                    phase_d = '0;
                    if (!en) state_d = IDLE;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs decode the next phase with the next shadow set so that the
    // registered outputs line up with the phase counter.
    always_comb begin
        run_n   = (state_d == RUN);
        c_ext   = {1'b0, phase_d};
        p2_end  = {1'b0, sh_p2st_d} + {1'b0, sh_p2wid_d};
        off_end = {1'b0, sh_offr_d_d} + {1'b0, sh_p1wid_d};
        win_p1  = sh_pu_d && (phase_d < sh_p1wid_d);
        win_p2  = (phase_d >= sh_p2st_d) && (c_ext < p2_end);
        win_off = sh_doub_d && (phase_d >= sh_offr_d_d) && (c_ext < off_end);

        pulse_d    = run_n && (win_p1 || win_p2 || win_off);
        sync_d     = run_n && (phase_d >= sh_s_up_d);
        att_gate_d = run_n && (phase_d < sh_att_d_d);
        stb_d      = run_n && (phase_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            sh_per_q    <= RST_PER;
            sh_p1wid_q  <= RST_P1WID;
            sh_p2st_q   <= RST_P2ST;
            sh_p2wid_q  <= RST_P2WID;
            sh_s_up_q   <= RST_S_UP;
            sh_att_d_q  <= RST_ATT_D;
            sh_offr_d_q <= RST_OFFR_D;
            sh_pu_q     <= 1'b1;
            sh_doub_q   <= 1'b0;
            pulse_q     <= 1'b0;
            sync_q      <= 1'b0;
            att_gate_q  <= 1'b0;
            stb_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            sh_per_q    <= sh_per_d;
            sh_p1wid_q  <= sh_p1wid_d;
            sh_p2st_q   <= sh_p2st_d;
            sh_p2wid_q  <= sh_p2wid_d;
            sh_s_up_q   <= sh_s_up_d;
            sh_att_d_q  <= sh_att_d_d;
            sh_offr_d_q <= sh_offr_d_d;
            sh_pu_q     <= sh_pu_d;
            sh_doub_q   <= sh_doub_d;
            pulse_q     <= pulse_d;
            sync_q      <= sync_d;
            att_gate_q  <= att_gate_d;
            stb_q       <= stb_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign pulse   = pulse_q;
    assign sync    = sync_q;
    assign att     = att_gate_q;
    assign stb     = stb_q;
    assign busy    = (state_q != IDLE);
    assign cfg_err = cfg_err_q;

endmodule
